// File: rtl/nn_pkg.sv
// Shared definitions for the dense-layer compute blocks.
//   state_e    : compute FSM states (2-bit encoding, StIdle = 0)
//   W_DEFAULT  : default weight/activation/output width
//   acc_width  : accumulator width that cannot overflow for N signed WxW products
package nn_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StScale = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned W_DEFAULT = 8;

  function automatic int unsigned acc_width(input int unsigned w, input int unsigned n);
    return 2 * w + $clog2(n);
  endfunction

endpackage

// File: rtl/nn_requant.sv
// Requantise one accumulator lane: arithmetic right shift (floor), saturate to the
// signed W-bit range, then optionally clamp negatives to zero.
//   i_acc : signed accumulator, ACC_W bits
//   o_q   : requantised two's-complement result, W bits
module nn_requant
  import nn_pkg::*;
#(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned W     = 8,
  parameter int unsigned SHIFT = 7,
  parameter int unsigned RELU  = 1
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic        [W-1:0]     o_q
);

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W - W + 1){1'b1}}, {(W - 1){1'b0}}};

  logic signed [ACC_W-1:0] w_shr;

  assign w_shr = i_acc >>> SHIFT;

  always_comb begin
    o_q = w_shr[W-1:0];
    if (w_shr > SAT_HI) begin
      o_q = SAT_HI[W-1:0];
    end else if (w_shr < SAT_LO) begin
      o_q = SAT_LO[W-1:0];
    end
    if ((RELU != 0) && w_shr[ACC_W-1]) begin
      o_q = '0;
    end
  end

endmodule

// File: rtl/dense_layer1_compute.sv
// Layer-1 fully-connected compute stage: OUT_SIZE parallel MAC lanes walk the input
// vector one element per cycle, then each lane is requantised into o_data_out.
//   i_clk        : clock, all state changes on posedge
//   i_rst_n      : synchronous active-low reset
//   i_start      : level request, sampled only in StIdle
//   i_weights_in : neuron o, input i at [(o*IN_SIZE+i)*W +: W]; held stable by producer
//   i_data_in    : element i at [i*W +: W]; held stable by producer
//   o_data_out   : neuron o at [o*W +: W], registered, held until the next result
//   o_done       : registered copy of (state == StDone), so it trails the state by one
//                  cycle: rises IN_SIZE+2 edges after the start sample
module dense_layer1_compute
  import nn_pkg::*;
#(
  parameter int unsigned IN_SIZE  = 256,
  parameter int unsigned OUT_SIZE = 8,
  parameter int unsigned W        = W_DEFAULT,
  parameter int unsigned SHIFT    = 7,
  parameter int unsigned RELU     = 1,
  parameter int unsigned ACC_W    = acc_width(W, IN_SIZE)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [IN_SIZE*OUT_SIZE*W-1:0]  i_weights_in,
  input  logic [IN_SIZE*W-1:0]           i_data_in,
  output logic [OUT_SIZE*W-1:0]          o_data_out,
  output logic                           o_done
);

  localparam int unsigned IDX_W = $clog2(IN_SIZE) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_SIZE - 1);

  state_e                r_state, w_state_d;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-2:0]      w_sel;
  logic                  r_done;
  logic [OUT_SIZE*W-1:0] r_data_out;
  logic [OUT_SIZE*W-1:0] w_q_all;
  logic                  w_clear, w_accum, w_scale;
  logic signed [W-1:0]   w_x;

  // Operand select is a plain combinational mux; the MAC has no pipeline register.
  assign w_sel = r_idx[IDX_W-2:0];
  assign w_x   = i_data_in[w_sel*W +: W];

  always_comb begin
    w_state_d = r_state;
    w_clear   = 1'b0;
    w_accum   = 1'b0;
    w_scale   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_clear   = 1'b1;
          w_state_d = StAccum;
        end
      end
      StAccum: begin
        w_accum = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_d = StScale;
        end
      end
      StScale: begin
        w_scale   = 1'b1;
        w_state_d = StDone;
      end
      StDone: begin
        if (!i_start) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state <= w_state_d;
      r_done  <= (r_state == StDone);
      if (w_clear) begin
        r_idx <= '0;
      end else if (w_accum) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_scale) begin
        r_data_out <= w_q_all;
      end
    end
  end

  for (genvar o = 0; o < OUT_SIZE; o++) begin : g_lane
    logic signed [W-1:0]     w_w;
    logic signed [2*W-1:0]   w_prod;
    logic signed [ACC_W-1:0] r_acc;
    logic        [W-1:0]     w_q;

    assign w_w    = i_weights_in[(o*IN_SIZE + w_sel)*W +: W];
    assign w_prod = w_w * w_x;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n || w_clear) begin
        r_acc <= '0;
      end else if (w_accum) begin
        r_acc <= r_acc + {{(ACC_W - 2*W){w_prod[2*W-1]}}, w_prod};
      end
    end

    nn_requant #(
      .ACC_W (ACC_W),
      .W     (W),
      .SHIFT (SHIFT),
      .RELU  (RELU)
    ) u_requant (
      .i_acc (r_acc),
      .o_q   (w_q)
    );

    assign w_q_all[o*W +: W] = w_q;
  end

  assign o_data_out = r_data_out;
  assign o_done     = r_done;

endmodule

// File: tb/tb_dense_layer1_compute.sv
module tb_dense_layer1_compute;

  localparam int IN   = 256;
  localparam int OUT  = 8;
  localparam int W    = 8;
  localparam int NCFG = 5;
  localparam int LAT  = IN + 2;

  // Configurations exercised side by side (index 0 is the rightmost entry).
  localparam logic [NCFG-1:0][3:0] CFG_SHIFT = {4'd8, 4'd7, 4'd7, 4'd2, 4'd0};
  localparam logic [NCFG-1:0]      CFG_RELU  = 5'b00111;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [IN*OUT*W-1:0]   weights;
  logic [IN*W-1:0]       data;
  logic [OUT*W-1:0]      dout   [NCFG];
  logic                  done_v [NCFG];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NCFG; k++) begin : g_dut
    dense_layer1_compute #(
      .IN_SIZE  (IN),
      .OUT_SIZE (OUT),
      .W        (W),
      .SHIFT    (int'(CFG_SHIFT[k])),
      .RELU     (int'(CFG_RELU[k]))
    ) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_weights_in (weights),
      .i_data_in    (data),
      .o_data_out   (dout[k]),
      .o_done       (done_v[k])
    );
  end

  // Stimulus values as plain integers; the buses are built from these.
  int wv [OUT][IN];
  int xv [IN];

  // Behavioural reference.
  logic [OUT*W-1:0] m_exp [NCFG];
  logic [OUT*W-1:0] m_out [NCFG];
  bit               m_done;
  bit               m_hold;
  int               m_left;

  function automatic logic [7:0] requant(input int acc, input int sh, input bit relu);
    int q;
    logic [31:0] qv;
    q = acc >>> sh;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    if (relu && q < 0) q = 0;
    qv = q;
    return qv[7:0];
  endfunction

  function automatic void compute_exp();
    int acc [OUT];
    for (int o = 0; o < OUT; o++) begin
      acc[o] = 0;
      for (int i = 0; i < IN; i++) acc[o] += wv[o][i] * xv[i];
    end
    for (int k = 0; k < NCFG; k++)
      for (int o = 0; o < OUT; o++)
        m_exp[k][o*W +: W] = requant(acc[o], int'(CFG_SHIFT[k]), CFG_RELU[k]);
  endfunction

  // Timing from the start sample T: results appear after T+IN+1, done after T+IN+2,
  // done stays up until the edge after start is seen low.
  always @(posedge clk) begin
    bit prev_hold;
    prev_hold = m_hold;
    if (!rst_n) begin
      m_left = 0;
      m_hold = 0;
      m_done = 0;
      for (int k = 0; k < NCFG; k++) m_out[k] = '0;
    end else begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          for (int k = 0; k < NCFG; k++) m_out[k] = m_exp[k];
          m_hold = 1;
        end
      end else if (m_hold) begin
        if (!start) m_hold = 0;
      end else if (start) begin
        compute_exp();
        m_left = IN + 1;
      end
      m_done = prev_hold;
    end
  end

  // Every-cycle comparison of all DUT instances against the reference.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NCFG; k++) begin
      n_tests++;
      if (done_v[k] !== m_done) begin
        n_fail++;
        $display("FAIL done cfg%0d t=%0t: got %b want %b", k, $time, done_v[k], m_done);
      end
      n_tests++;
      if (dout[k] !== m_out[k]) begin
        n_fail++;
        $display("FAIL data_out cfg%0d t=%0t: got %h want %h", k, $time, dout[k], m_out[k]);
      end
    end
  end

  task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic load_bus();
    for (int o = 0; o < OUT; o++)
      for (int i = 0; i < IN; i++) begin
        logic [31:0] v;
        v = wv[o][i];
        weights[(o*IN + i)*W +: W] = v[7:0];
      end
    for (int i = 0; i < IN; i++) begin
      logic [31:0] v;
      v = xv[i];
      data[i*W +: W] = v[7:0];
    end
  endtask

  // Raise start, return the number of edges from the start sample to done seen high.
  task automatic run_vec(output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!done_v[0] && lat < 400);
  endtask

  task automatic end_vec(input int hold);
    repeat (hold) @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill(input int wlo, input int whi, input int xlo, input int xhi);
    for (int o = 0; o < OUT; o++)
      for (int i = 0; i < IN; i++) wv[o][i] = wlo + int'($urandom_range(0, whi - wlo));
    for (int i = 0; i < IN; i++) xv[i] = xlo + int'($urandom_range(0, xhi - xlo));
    load_bus();
  endtask

  initial begin
    int lat;
    rst_n   = 1'b0;
    start   = 1'b0;
    weights = '0;
    data    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NCFG; k++) check_lit("reset data_out", dout[k], 64'd0);
    check_lit("reset done", {63'd0, done_v[0]}, 64'd0);

    // All ones: acc = 256 per lane.
    fill(1, 1, 1, 1);
    run_vec(lat);
    check_lit("latency all-ones", 64'(lat), 64'(LAT));
    check_lit("all-ones shift0", dout[0], {8{8'd127}});
    check_lit("all-ones shift2", dout[1], {8{8'd64}});
    check_lit("all-ones shift7", dout[2], {8{8'd2}});
    end_vec(0);

    // Negative: acc = -768, >>>7 = -6.
    fill(-1, -1, 3, 3);
    run_vec(lat);
    check_lit("latency negative", 64'(lat), 64'(LAT));
    check_lit("negative relu1", dout[2], 64'd0);
    check_lit("negative relu0", dout[3], {8{8'hFA}});
    end_vec(1);

    // Per-lane independence: lane o weight o+1, acc = 256*(o+1), >>>8 = o+1.
    for (int o = 0; o < OUT; o++)
      for (int i = 0; i < IN; i++) wv[o][i] = o + 1;
    for (int i = 0; i < IN; i++) xv[i] = 1;
    load_bus();
    run_vec(lat);
    check_lit("per-lane shift8", dout[4],
              {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    end_vec(2);

    // Random vectors, alternating full-range and small-range operands.
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) fill(-128, 127, -128, 127);
      else fill(-3, 3, -3, 3);
      run_vec(lat);
      check_lit("latency random", 64'(lat), 64'(LAT));
      end_vec(int'($urandom_range(0, 3)));
    end

    // Reset while accumulating at idx = 100.
    fill(-20, 20, -20, 20);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NCFG; k++) check_lit("mid-reset data_out", dout[k], 64'd0);
    check_lit("mid-reset done", {63'd0, done_v[0]}, 64'd0);
    run_vec(lat);
    check_lit("latency after reset", 64'(lat), 64'(LAT));

    // Start held high: no recomputation even when the operands change.
    fill(-128, 127, -128, 127);
    repeat (20) @(negedge clk);
    check_lit("held done", {63'd0, done_v[0]}, 64'd1);
    start = 1'b0;
    run_vec(lat);
    check_lit("latency restart", 64'(lat), 64'(LAT));
    end_vec(0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
